// File: rtl/oled_axil_pkg.sv
// Shared constants and FSM state types for the OLED AXI4-Lite register file.
package oled_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_CMD     = 2'd1;
    localparam logic [1:0] REG_DATA    = 2'd2;
    localparam logic [1:0] REG_SCRATCH = 2'd3;

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_HAVE_AW = 2'd1,
        W_HAVE_W  = 2'd2,
        W_RESP    = 2'd3
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    function automatic logic [3:0] reg_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/oled_axil_strb_merge.sv
// Byte-wise merge of a register's old value with new write data under WSTRB.
// Purely combinational, no flow control.
module oled_axil_strb_merge (
    input  logic [31:0] i_old,
    input  logic [31:0] i_new,
    input  logic [3:0]  i_strb,
    output logic [31:0] o_merged
);

    always_comb begin
        o_merged = i_old;
        for (int b = 0; b < 4; b++) begin
            if (i_strb[b]) begin
                o_merged[b*8 +: 8] = i_new[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/oled_axil_regs.sv
// AXI4-Lite slave with four 32-bit registers; write B and read R valid 1 cycle after handshake.
// One write and one read outstanding; B/R held until BREADY/RREADY, address channels stalled meanwhile.
module oled_axil_regs
    import oled_axil_pkg::*;
#(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 4,
    parameter logic [31:0] C_RESET_VALUE      = 32'h0
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0]   reg_q,
    output logic [3:0]                        reg_wr_pulse
);

    w_state_t          r_wstate, w_wstate_nxt;
    r_state_t          r_rstate, w_rstate_nxt;
    logic [3:0][31:0]  r_regs;
    logic [1:0]        r_awidx;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic [3:0]        r_wr_pulse;
    logic [31:0]       r_rdata;
    logic              r_out_en;

    logic        w_awready, w_wready, w_bvalid, w_arready, w_rvalid;
    logic        w_lat_aw, w_lat_w, w_we, w_re;
    logic [1:0]  w_widx;
    logic [31:0] w_wdat, w_merged, w_rd_sel;
    logic [3:0]  w_wstb;
    logic        w_unused;

    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

    // Merge sources: whichever half of the write arrived earlier comes from its latch.
    assign w_widx = (r_wstate == W_HAVE_AW) ? r_awidx : S_AXI_AWADDR[3:2];
    assign w_wdat = (r_wstate == W_HAVE_W)  ? r_wdata : S_AXI_WDATA;
    assign w_wstb = (r_wstate == W_HAVE_W)  ? r_wstrb : S_AXI_WSTRB;

    oled_axil_strb_merge u_merge (
        .i_old    (r_regs[w_widx]),
        .i_new    (w_wdat),
        .i_strb   (w_wstb),
        .o_merged (w_merged)
    );

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_awready    = 1'b0;
        w_wready     = 1'b0;
        w_bvalid     = 1'b0;
        w_lat_aw     = 1'b0;
        w_lat_w      = 1'b0;
        w_we         = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                w_awready = r_out_en;
                w_wready  = r_out_en;
                if (S_AXI_AWVALID && S_AXI_WVALID && r_out_en) begin
                    w_we         = 1'b1;
                    w_wstate_nxt = W_RESP;
                end else if (S_AXI_AWVALID && r_out_en) begin
                    w_lat_aw     = 1'b1;
                    w_wstate_nxt = W_HAVE_AW;
                end else if (S_AXI_WVALID && r_out_en) begin
                    w_lat_w      = 1'b1;
                    w_wstate_nxt = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                w_wready = 1'b1;
                if (S_AXI_WVALID) begin
                    w_we         = 1'b1;
                    w_wstate_nxt = W_RESP;
                end
            end
            W_HAVE_W: begin
                w_awready = 1'b1;
                if (S_AXI_AWVALID) begin
                    w_we         = 1'b1;
                    w_wstate_nxt = W_RESP;
                end
            end
            W_RESP: begin
                w_bvalid = 1'b1;
                if (S_AXI_BREADY) begin
                    w_wstate_nxt = W_IDLE;
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        w_arready    = 1'b0;
        w_rvalid     = 1'b0;
        w_re         = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                w_arready = r_out_en;
                if (S_AXI_ARVALID && r_out_en) begin
                    w_re         = 1'b1;
                    w_rstate_nxt = R_DATA;
                end
            end
            R_DATA: begin
                w_rvalid = 1'b1;
                if (S_AXI_RREADY) begin
                    w_rstate_nxt = R_IDLE;
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        w_rd_sel = r_regs[REG_CTRL];
        case (S_AXI_ARADDR[3:2])
            REG_CTRL:    w_rd_sel = r_regs[REG_CTRL];
            REG_CMD:     w_rd_sel = r_regs[REG_CMD];
            REG_DATA:    w_rd_sel = r_regs[REG_DATA];
            REG_SCRATCH: w_rd_sel = r_regs[REG_SCRATCH];
            default:     w_rd_sel = r_regs[REG_CTRL];
        endcase
    end

    // r_out_en keeps every READY low while reset is asserted and for the first edge after.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wstate   <= W_IDLE;
            r_awidx    <= 2'd0;
            r_wdata    <= 32'd0;
            r_wstrb    <= 4'd0;
            r_regs     <= {4{C_RESET_VALUE}};
            r_wr_pulse <= 4'd0;
            r_out_en   <= 1'b0;
        end else begin
            r_out_en   <= 1'b1;
            r_wstate   <= w_wstate_nxt;
            r_wr_pulse <= w_we ? reg_onehot(w_widx) : 4'd0;
            if (w_lat_aw) begin
                r_awidx <= S_AXI_AWADDR[3:2];
            end
            if (w_lat_w) begin
                r_wdata <= S_AXI_WDATA;
                r_wstrb <= S_AXI_WSTRB;
            end
            if (w_we) begin
                r_regs[w_widx] <= w_merged;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rstate <= R_IDLE;
            r_rdata  <= 32'd0;
        end else begin
            r_rstate <= w_rstate_nxt;
            if (w_re) begin
                r_rdata <= w_rd_sel;
            end
        end
    end

    assign S_AXI_AWREADY = w_awready;
    assign S_AXI_WREADY  = w_wready;
    assign S_AXI_BVALID  = w_bvalid;
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_ARREADY = w_arready;
    assign S_AXI_RVALID  = w_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = RESP_OKAY;
    assign reg_q         = r_regs;
    assign reg_wr_pulse  = r_wr_pulse;

endmodule

// File: tb/tb_oled_axil_regs.sv
// Self-checking bench for oled_axil_regs: vector table plus hand-written handshake sequences.
module tb_oled_axil_regs;

    logic         aclk = 1'b0;
    logic         arstn;
    logic [3:0]   awaddr, araddr;
    logic [2:0]   awprot, arprot;
    logic         awvalid, wvalid, bready, arvalid, rready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         awready, wready, bvalid, arready, rvalid;
    logic [1:0]   bresp, rresp;
    logic [31:0]  rdata;
    logic [127:0] reg_q;
    logic [3:0]   pulse;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    always #5 aclk = ~aclk;

    oled_axil_regs dut (
        .ACLK          (aclk),
        .ARESETN       (arstn),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .reg_q         (reg_q),
        .reg_wr_pulse  (pulse)
    );

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [3:0]  pulse;
        logic [3:0]  raddr;
        logic [31:0] rexp;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: read data with empty scoreboard got %0h expected none", tag, rdata);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_rdata"}, rdata, e);
            chk({tag, "_rresp"}, rresp, 2'b00);
        end
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [3:0] exp_pulse, input string tag);
        int n;
        @(negedge aclk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while (!(awready && wready) && n < 20) begin
            @(negedge aclk);
            n++;
        end
        chk({tag, "_awwready"}, awready && wready, 1'b1);
        @(negedge aclk);
        awvalid = 1'b0; wvalid = 1'b0;
        chk({tag, "_bvalid"}, bvalid, 1'b1);
        chk({tag, "_bresp"}, bresp, 2'b00);
        chk({tag, "_pulse"}, pulse, exp_pulse);
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        chk({tag, "_pulse_clr"}, pulse, 4'b0000);
        chk({tag, "_bvalid_clr"}, bvalid, 1'b0);
    endtask

    task automatic do_read(input logic [3:0] a, input logic [31:0] exp, input string tag);
        int n;
        exp_q.push_back(exp);
        @(negedge aclk);
        araddr = a; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin
            @(negedge aclk);
            n++;
        end
        chk({tag, "_arready"}, arready, 1'b1);
        @(negedge aclk);
        arvalid = 1'b0;
        chk({tag, "_rvalid"}, rvalid, 1'b1);
        pop_check(tag);
        rready = 1'b1;
        @(negedge aclk);
        rready = 1'b0;
        chk({tag, "_rvalid_clr"}, rvalid, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{4'h0, 32'h0000_0001, 4'hF, 4'b0001, 4'h0, 32'h0000_0001};
        tbl[1] = '{4'h4, 32'h0000_0002, 4'hF, 4'b0010, 4'h4, 32'h0000_0002};
        tbl[2] = '{4'h8, 32'h0000_0003, 4'hF, 4'b0100, 4'h8, 32'h0000_0003};
        tbl[3] = '{4'hC, 32'h0000_0004, 4'hF, 4'b1000, 4'hC, 32'h0000_0004};
        tbl[4] = '{4'h8, 32'h1122_3344, 4'hF, 4'b0100, 4'h8, 32'h1122_3344};
        tbl[5] = '{4'h8, 32'hAABB_CCDD, 4'h5, 4'b0100, 4'h8, 32'h11BB_33DD};
        tbl[6] = '{4'h8, 32'hFFFF_FFFF, 4'h0, 4'b0100, 4'h8, 32'h11BB_33DD};
        tbl[7] = '{4'h3, 32'h0000_0055, 4'hF, 4'b0001, 4'h1, 32'h0000_0055};

        arstn = 1'b0;
        awaddr = 4'h0; araddr = 4'h0; awprot = 3'd0; arprot = 3'd0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        wdata = 32'd0; wstrb = 4'h0;

        // Reset state
        @(negedge aclk);
        @(negedge aclk);
        chk("rst_hs", {awready, wready, bvalid, arready, rvalid}, 5'b0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_pulse", pulse, 4'd0);
        chk("rst_regs", reg_q, 128'd0);
        arstn = 1'b1;
        @(negedge aclk);
        @(negedge aclk);

        // Table: four writes, then read all back, then strobe cases write+read
        for (int i = 0; i < 4; i++) do_write(tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, tbl[i].pulse, $sformatf("wr%0d", i));
        chk("reg_q_after4", reg_q, {32'd4, 32'd3, 32'd2, 32'd1});
        for (int i = 0; i < 4; i++) do_read(tbl[i].raddr, tbl[i].rexp, $sformatf("rd%0d", i));
        for (int i = 4; i < 8; i++) begin
            do_write(tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, tbl[i].pulse, $sformatf("wr%0d", i));
            do_read(tbl[i].raddr, tbl[i].rexp, $sformatf("rd%0d", i));
        end

        // W three cycles ahead of AW
        @(negedge aclk);
        wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
        chk("wfirst_wready", wready, 1'b1);
        @(negedge aclk);
        wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("wfirst_wready_low%0d", i), wready, 1'b0);
            chk($sformatf("wfirst_awready%0d", i), awready, 1'b1);
            chk($sformatf("wfirst_nob%0d", i), bvalid, 1'b0);
            if (i < 2) @(negedge aclk);
        end
        awaddr = 4'h4; awvalid = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0;
        chk("wfirst_bvalid", bvalid, 1'b1);
        chk("wfirst_pulse", pulse, 4'b0010);
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        do_read(4'h4, 32'hDEAD_BEEF, "wfirst_rd");

        // B backpressure with a second write pending on the bus
        @(negedge aclk);
        awaddr = 4'h0; wdata = 32'hCAFE_F00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge aclk);
        awaddr = 4'h4; wdata = 32'h1234_5678;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bstall_bvalid%0d", i), bvalid, 1'b1);
            chk($sformatf("bstall_rdy%0d", i), {awready, wready}, 2'b00);
            @(negedge aclk);
        end
        awvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        chk("bstall_done", bvalid, 1'b0);

        // R backpressure with a second read pending on the bus
        exp_q.push_back(32'hCAFE_F00D);
        @(negedge aclk);
        araddr = 4'h0; arvalid = 1'b1;
        @(negedge aclk);
        araddr = 4'h4;
        pop_check("rstall");
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("rstall_rvalid%0d", i), rvalid, 1'b1);
            chk($sformatf("rstall_rdata%0d", i), rdata, 32'hCAFE_F00D);
            chk($sformatf("rstall_arready%0d", i), arready, 1'b0);
            @(negedge aclk);
        end
        arvalid = 1'b0;
        rready = 1'b1;
        @(negedge aclk);
        rready = 1'b0;
        chk("rstall_done", rvalid, 1'b0);
        do_read(4'h4, 32'hDEAD_BEEF, "bstall_rd4");

        // Same-cycle read and write of the scratch register
        exp_q.push_back(32'h0000_0004);
        @(negedge aclk);
        awaddr = 4'hC; wdata = 32'h99; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 4'hC; arvalid = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("same_bvalid", bvalid, 1'b1);
        chk("same_rvalid", rvalid, 1'b1);
        pop_check("same_old");
        bready = 1'b1; rready = 1'b1;
        @(negedge aclk);
        bready = 1'b0; rready = 1'b0;
        do_read(4'hC, 32'h99, "same_new");

        // Reset while sitting in W_HAVE_AW
        @(negedge aclk);
        awaddr = 4'h0; awvalid = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0;
        chk("midrst_haveaw", {awready, wready}, 2'b01);
        #2 arstn = 1'b0;
        #1;
        chk("midrst_hs", {awready, wready, bvalid, arready, rvalid}, 5'b0);
        chk("midrst_rdata", rdata, 32'd0);
        chk("midrst_pulse", pulse, 4'd0);
        chk("midrst_regs", reg_q, 128'd0);
        @(negedge aclk);
        arstn = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        chk("postrst_nob", bvalid, 1'b0);
        do_write(4'h8, 32'h0000_0077, 4'hF, 4'b0100, "postrst_wr");
        do_read(4'h8, 32'h0000_0077, "postrst_rd8");
        do_read(4'h0, 32'h0000_0000, "postrst_rd0");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
